// File: rtl/spi_frame_receiver_if.sv
// Bus bundle for the SPI frame receiver: SPI pins, response-byte load and
// the decoded-frame outputs handed to the RAM command decoder.
interface spi_frame_receiver_if #(
    parameter int unsigned FRAME_BITS = 16
);
    logic                  spi_sclk;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic [7:0]            tx_data;
    logic                  tx_load;
    logic [FRAME_BITS-1:0] incoming_data;
    logic                  data_valid;
    logic                  frame_error;
    logic                  busy;

    // Drives the SPI pins and the response byte; observes decoded frames.
    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_load,
        input  spi_miso, incoming_data, data_valid, frame_error, busy
    );

    // The receiver itself.
    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_load,
        output spi_miso, incoming_data, data_valid, frame_error, busy
    );
endinterface

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave front end. Oversamples SCLK/CS_N/MOSI in the system clock
// domain, assembles MSB-first frames and shifts a response byte out on MISO.
module spi_frame_receiver #(
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    spi_frame_receiver_if.slave  io_bus
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    // Synchronizer chains; index 0 samples the pin, the top index is the safe copy.
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    // Fills with ones after reset; the chains hold real pin values once full.
    logic [SYNC_STAGES:0]   r_fill;
    logic                   r_armed;
    logic [7:0]             r_tx_hold;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [FRAME_BITS-1:0]  r_tx_shift;
    logic [FRAME_BITS-1:0]  r_incoming;
    logic                   r_data_valid;
    logic                   r_frame_error;
    logic                   r_busy;
    logic                   r_miso;
    logic                   r_overrun;

    logic                   w_sclk;
    logic                   w_cs;
    logic                   w_mosi;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_fall;
    logic [7:0]             w_tx_byte;
    logic [FRAME_BITS-1:0]  w_tx_next;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;
    // A load coinciding with frame start feeds that same frame.
    assign w_tx_byte   = io_bus.tx_load ? io_bus.tx_data : r_tx_hold;
    assign w_tx_next   = r_tx_shift << 1;

    // Synchronize the asynchronous SPI pins and keep one delayed copy for edges.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
            r_fill      <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], io_bus.spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], io_bus.spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], io_bus.spi_mosi};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
            r_fill      <= {r_fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Arm only on a genuinely observed CS_N high, not on the reset value of the chain.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_armed <= 1'b0;
        end else if (r_fill[SYNC_STAGES] && w_cs) begin
            r_armed <= 1'b1;
        end
    end

    // Capture the response byte whenever it is offered.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_tx_hold <= 8'h00;
        end else if (io_bus.tx_load) begin
            r_tx_hold <= io_bus.tx_data;
        end
    end

    // Frame FSM: idle -> shift bits in/out -> hold result until CS_N rises.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= StIdle;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_tx_shift    <= '0;
            r_incoming    <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
            r_miso        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_cs_fall && r_armed) begin
                        r_state      <= StShift;
                        r_bit_cnt    <= '0;
                        r_shift      <= '0;
                        r_data_valid <= 1'b0;
                        r_busy       <= 1'b1;
                        r_overrun    <= 1'b0;
                        r_tx_shift   <= {w_tx_byte, {(FRAME_BITS-8){1'b0}}};
                        r_miso       <= w_tx_byte[7];
                    end
                end
                StShift: begin
                    if (w_cs) begin
                        // Deselected before the frame was complete.
                        r_frame_error <= 1'b1;
                        r_busy        <= 1'b0;
                        r_miso        <= 1'b0;
                        r_state       <= StIdle;
                    end else begin
                        if (w_sclk_rise) begin
                            r_shift   <= {r_shift[FRAME_BITS-2:0], w_mosi};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                                r_incoming   <= {r_shift[FRAME_BITS-2:0], w_mosi};
                                r_data_valid <= 1'b1;
                                r_busy       <= 1'b0;
                                r_state      <= StDone;
                            end
                        end
                        if (w_sclk_fall) begin
                            r_tx_shift <= w_tx_next;
                            r_miso     <= w_tx_next[FRAME_BITS-1];
                        end
                    end
                end
                StDone: begin
                    if (w_cs) begin
                        r_frame_error <= r_overrun;
                        r_overrun     <= 1'b0;
                        r_miso        <= 1'b0;
                        r_state       <= StIdle;
                    end else if (w_sclk_rise) begin
                        // The last falling edge of a normal frame lands here, so
                        // only extra rising edges count as overrun.
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.spi_miso      = r_miso & ~w_cs;
    assign io_bus.incoming_data = r_incoming;
    assign io_bus.data_valid    = r_data_valid;
    assign io_bus.frame_error   = r_frame_error;
    assign io_bus.busy          = r_busy;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver: SCLK at clk/8, expected values by hand.
module tb_spi_frame_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_tests = 0;
    int          n_fail = 0;
    int          fe_cycles = 0;
    int          dv_rises = 0;
    logic        dv_prev = 1'b0;
    logic [15:0] miso_cap;
    int          fe_base;
    int          dv_base;

    spi_frame_receiver_if #(.FRAME_BITS(16)) bus ();

    spi_frame_receiver #(
        .FRAME_BITS (16),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Count frame_error high cycles and data_valid rising edges.
    always @(negedge clk) begin
        if (bus.frame_error === 1'b1) fe_cycles++;
        if (bus.data_valid === 1'b1 && dv_prev === 1'b0) dv_rises++;
        dv_prev = bus.data_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCLK period; MISO is captured just before the rising edge.
    task automatic spi_bit(input logic b);
        bus.spi_mosi = b;
        clk_wait(4);
        miso_cap = {miso_cap[14:0], bus.spi_miso};
        bus.spi_sclk = 1'b1;
        clk_wait(4);
        bus.spi_sclk = 1'b0;
    endtask

    // Send the first n bits of w, MSB first.
    task automatic spi_word(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) spi_bit(w[15-i]);
    endtask

    task automatic cs_start();
        bus.spi_cs_n = 1'b0;
        clk_wait(4);
    endtask

    task automatic cs_end();
        clk_wait(4);
        bus.spi_cs_n = 1'b1;
        clk_wait(6);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_load  = 1'b0;
        miso_cap     = 16'h0000;

        // Reset state
        clk_wait(5);
        check("rst_incoming", 32'(bus.incoming_data), 32'h0);
        check("rst_dv", 32'(bus.data_valid), 32'h0);
        check("rst_fe", 32'(bus.frame_error), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_miso", 32'(bus.spi_miso), 32'h0);
        rst_n = 1'b1;
        clk_wait(6);

        // 1: write frame A510 with data_valid latency on the 16th rise
        cs_start();
        spi_word(16'hA510, 15);
        check("t1_busy", 32'(bus.busy), 32'h1);
        bus.spi_mosi = 1'b0;
        clk_wait(4);
        bus.spi_sclk = 1'b1;
        clk_wait(2);
        check("t1_dv_early", 32'(bus.data_valid), 32'h0);
        clk_wait(1);
        check("t1_dv_rise", 32'(bus.data_valid), 32'h1);
        check("t1_incoming", 32'(bus.incoming_data), 32'hA510);
        clk_wait(1);
        bus.spi_sclk = 1'b0;
        cs_end();
        check("t1_dv_hold", 32'(bus.data_valid), 32'h1);
        check("t1_dv_rises", 32'(dv_rises), 32'd1);
        check("t1_fe", 32'(fe_cycles), 32'd0);
        check("t1_busy_end", 32'(bus.busy), 32'h0);

        // 2: read frame with response byte 3C
        bus.tx_data = 8'h3C;
        bus.tx_load = 1'b1;
        clk_wait(1);
        bus.tx_load = 1'b0;
        bus.tx_data = 8'hFF;
        cs_start();
        check("t2_dv_clr", 32'(bus.data_valid), 32'h0);
        check("t2_busy", 32'(bus.busy), 32'h1);
        miso_cap = 16'h0000;
        spi_word(16'h0032, 16);
        check("t2_miso", 32'(miso_cap), 32'h3C00);
        check("t2_incoming", 32'(bus.incoming_data), 32'h0032);
        check("t2_dv", 32'(bus.data_valid), 32'h1);
        cs_end();
        check("t2_miso_idle", 32'(bus.spi_miso), 32'h0);

        // 3: short frame of 9 bits
        cs_start();
        spi_word(16'hFFFF, 9);
        check("t3_busy", 32'(bus.busy), 32'h1);
        fe_base = fe_cycles;
        bus.spi_cs_n = 1'b1;
        clk_wait(6);
        check("t3_fe_pulse", 32'(fe_cycles - fe_base), 32'd1);
        check("t3_incoming", 32'(bus.incoming_data), 32'h0032);
        check("t3_dv", 32'(bus.data_valid), 32'h0);
        check("t3_busy_end", 32'(bus.busy), 32'h0);

        // 4: overrun with 18 SCLK pulses
        cs_start();
        spi_word(16'hC3F1, 16);
        fe_base = fe_cycles;
        spi_bit(1'b1);
        spi_bit(1'b1);
        check("t4_incoming", 32'(bus.incoming_data), 32'hC3F1);
        check("t4_dv", 32'(bus.data_valid), 32'h1);
        check("t4_fe_early", 32'(fe_cycles - fe_base), 32'd0);
        cs_end();
        check("t4_fe_pulse", 32'(fe_cycles - fe_base), 32'd1);
        check("t4_dv_hold", 32'(bus.data_valid), 32'h1);

        // 5: reset mid-frame, then a clean frame 5521
        dv_base = dv_rises;
        fe_base = fe_cycles;
        cs_start();
        spi_word(16'h5521, 8);
        rst_n = 1'b0;
        clk_wait(3);
        check("t5_rst_dv", 32'(bus.data_valid), 32'h0);
        check("t5_rst_busy", 32'(bus.busy), 32'h0);
        check("t5_rst_incoming", 32'(bus.incoming_data), 32'h0);
        rst_n = 1'b1;
        spi_word(16'h2100, 8);
        clk_wait(4);
        check("t5_no_dv", 32'(dv_rises - dv_base), 32'd0);
        check("t5_no_fe", 32'(fe_cycles - fe_base), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'h0);
        bus.spi_cs_n = 1'b1;
        clk_wait(6);
        cs_start();
        spi_word(16'h5521, 16);
        check("t5_incoming", 32'(bus.incoming_data), 32'h5521);
        check("t5_dv", 32'(bus.data_valid), 32'h1);
        check("t5_dv_rises", 32'(dv_rises - dv_base), 32'd1);

        // 6: back-to-back frames with minimum CS_N high time
        clk_wait(4);
        bus.spi_cs_n = 1'b1;
        clk_wait(4);
        cs_start();
        spi_word(16'h1111, 16);
        check("t6_first", 32'(bus.incoming_data), 32'h1111);
        clk_wait(4);
        bus.spi_cs_n = 1'b1;
        clk_wait(4);
        bus.spi_cs_n = 1'b0;
        clk_wait(2);
        check("t6_dv_before_fall", 32'(bus.data_valid), 32'h1);
        clk_wait(1);
        check("t6_dv_drop", 32'(bus.data_valid), 32'h0);
        check("t6_hold_data", 32'(bus.incoming_data), 32'h1111);
        clk_wait(1);
        spi_word(16'h2222, 16);
        check("t6_second", 32'(bus.incoming_data), 32'h2222);
        check("t6_dv", 32'(bus.data_valid), 32'h1);
        cs_end();
        check("t6_no_fe", 32'(fe_cycles - fe_base), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
